// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and the SRAM slave.
// HREADY is the bus-level ready, owned by the interconnect, so it sits on
// the master side.
interface ahb_lite_sram_slave_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
);
    logic                 HSEL;
    logic [ADDRWIDTH-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [2:0]           HBURST;
    logic [DATAWIDTH-1:0] HWDATA;
    logic                 HREADY;
    logic                 HREADYOUT;
    logic                 HRESP;
    logic [DATAWIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-organised register-array memory.
// Byte/halfword/word transfers, WAIT_STATES stall cycles per OKAY data
// phase, two-cycle ERROR response for illegal accesses. DATAWIDTH must be 32.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no data phase in progress, zero-wait OKAY
// WAIT   | legal transfer stalled, HREADYOUT low, counter running
// DATA   | completing cycle of a legal transfer (read data / write commit)
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, HREADYOUT high, no memory update
module ahb_lite_sram_slave #(
    parameter int DATAWIDTH   = 32,
    parameter int ADDRWIDTH   = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            lane_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [3:0]            byte_en;
    logic [DATAWIDTH-1:0]  mem [MEM_DEPTH];

    logic                  accept_window;
    logic                  capture;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  illegal;
    logic [ADDRWIDTH-3:0]  word_addr;
    logic                  unused_bits;

    // HBURST is ignored and HTRANS[0] only distinguishes NONSEQ from SEQ.
    assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

    // An address phase can only be taken in a cycle where this slave is ready.
    assign accept_window = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign capture       = accept_window && bus.HSEL && bus.HREADY && bus.HTRANS[1];

    // Power-of-two depth: any word-address bit at or above IDX_W is out of range.
    assign word_addr     = bus.HADDR[ADDRWIDTH-1:2];
    assign out_of_range  = (word_addr >> IDX_W) != '0;
    assign misaligned    = ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
                           ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
    assign illegal       = (bus.HSIZE > 3'b010) || misaligned || out_of_range;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a capture in DATA/ERR2 pipelines the next transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!capture) begin
                    state_nxt = S_IDLE;
                end else if (illegal) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_DATA;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_DATA;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address-phase registers and the wait-state down-counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q    <= '0;
            lane_q   <= 2'b00;
            size_q   <= 3'b000;
            write_q  <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            if (capture) begin
                idx_q   <= bus.HADDR[IDX_W+1:2];
                lane_q  <= bus.HADDR[1:0];
                size_q  <= bus.HSIZE;
                write_q <= bus.HWRITE;
            end
            if (capture && !illegal) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Little-endian byte lanes of the latched transfer.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'b000:  byte_en = 4'b0001 << lane_q;
            3'b001:  byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Write commit on the edge leaving DATA; reset forces IDLE so an
    // interrupted transfer never reaches this point.
    always_ff @(posedge HCLK) begin
        if ((state == S_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Response outputs; read data is only visible in a read DATA cycle.
    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;
        case (state)
            S_WAIT: bus.HREADYOUT = 1'b0;
            S_DATA: begin
                if (!write_q) begin
                    bus.HRDATA = mem[idx_q];
                end
            end
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            S_ERR2:  bus.HRESP = 1'b1;
            default: ;
        endcase
    end
endmodule
